// File: rtl/alu_instr_sequencer_if.sv
// Strobe/instruction bundle between the control-step sequencer (master) and the datapath (slave).
interface alu_instr_sequencer_if #(
   parameter int NREGS = 16,
   parameter int OPW   = 5
);
   logic             run;
   logic             step;
   logic [31:0]      ir;
   logic             pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in;
   logic             y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in;
   logic [NREGS-1:0] rin;
   logic [NREGS-1:0] rout;
   logic [OPW-1:0]   op_code;
   logic             illegal;
   logic             halted;

   modport master (
      input  run, step, ir,
      output pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in,
             y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in,
             rin, rout, op_code, illegal, halted
   );

   modport slave (
      output run, step, ir,
      input  pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in,
             y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in,
             rin, rout, op_code, illegal, halted
   );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Control-step FSM for the Phase 1 datapath: fetch in T0-T2, execute in T3-T6.
// Build option SINGLE_STEP_EN: every non-reset transition waits for a rising step pulse.
module alu_instr_sequencer #(
   parameter int NREGS = 16,
   parameter int OPW   = 5
) (
   input logic                   clk,
   input logic                   clr,
   alu_instr_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ILL, S_HALT
   } state_t;

   localparam logic [14:0] P_PC_OUT  = 15'h4000;
   localparam logic [14:0] P_PC_INC  = 15'h2000;
   localparam logic [14:0] P_MAR_IN  = 15'h1000;
   localparam logic [14:0] P_PC_IN   = 15'h0800;
   localparam logic [14:0] P_READ    = 15'h0400;
   localparam logic [14:0] P_MDR_IN  = 15'h0200;
   localparam logic [14:0] P_MDR_OUT = 15'h0100;
   localparam logic [14:0] P_IR_IN   = 15'h0080;
   localparam logic [14:0] P_Y_IN    = 15'h0040;
   localparam logic [14:0] P_ZLO_IN  = 15'h0020;
   localparam logic [14:0] P_ZHI_IN  = 15'h0010;
   localparam logic [14:0] P_ZLO_OUT = 15'h0008;
   localparam logic [14:0] P_ZHI_OUT = 15'h0004;
   localparam logic [14:0] P_LO_IN   = 15'h0002;
   localparam logic [14:0] P_HI_IN   = 15'h0001;

   state_t           state_q, state_d;
   logic             advance;
   logic [4:0]       opc;
   logic [3:0]       ra, rb, rc;
   logic             is_bin, is_wide, is_un, is_halt;
   logic [14:0]      strb;
   logic             rin_en, rout_en;
   logic [3:0]       rin_idx, rout_idx;
   logic [NREGS-1:0] rin_vec, rout_vec;
   logic [4:0]       op_sel;
   logic             ill_out, halt_out;
   logic             unused_bits;

   assign opc = bus.ir[31:27];
   assign ra  = bus.ir[26:23];
   assign rb  = bus.ir[22:19];
   assign rc  = bus.ir[18:15];

   always_comb begin
      is_bin  = opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                            5'b01000, 5'b01001, 5'b01010, 5'b01011};
      is_wide = opc inside {5'b01111, 5'b10000};
      is_un   = opc inside {5'b10001, 5'b10010};
      is_halt = (opc == 5'b11011);
   end

`ifdef SINGLE_STEP_EN
   logic step_q;
   // Rising-edge detect so a long step pulse still advances only one state.
   assign advance     = bus.step & ~step_q;
   assign unused_bits = ^bus.ir[14:0];
`else
   assign advance     = 1'b1;
   assign unused_bits = ^{bus.ir[14:0], bus.step};
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = bus.run ? S_T0 : S_IDLE;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2: begin
            if (is_bin || is_wide) state_d = S_T3;
            else if (is_un)        state_d = S_T4;
            else if (is_halt)      state_d = S_HALT;
            else                   state_d = S_ILL;
         end
         S_T3:   state_d = S_T4;
         S_T4:   state_d = S_T5;
         S_T5:   state_d = is_wide ? S_T6 : (bus.run ? S_T0 : S_IDLE);
         S_T6:   state_d = bus.run ? S_T0 : S_IDLE;
         S_ILL:  state_d = bus.run ? S_T0 : S_IDLE;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
`ifdef SINGLE_STEP_EN
         step_q  <= 1'b0;
`endif
      end else begin
         if (advance) state_q <= state_d;
`ifdef SINGLE_STEP_EN
         step_q  <= bus.step;
`endif
      end
   end

   always_comb begin
      strb     = '0;
      rin_en   = 1'b0;
      rin_idx  = ra;
      rout_en  = 1'b0;
      rout_idx = rb;
      op_sel   = '0;
      ill_out  = 1'b0;
      halt_out = 1'b0;
      case (state_q)
         S_T0: strb = P_PC_OUT | P_PC_INC | P_MAR_IN | P_ZLO_IN | P_ZHI_IN;
         S_T1: strb = P_ZLO_OUT | P_PC_IN | P_READ | P_MDR_IN;
         S_T2: strb = P_MDR_OUT | P_IR_IN;
         S_T3: begin
            strb    = P_Y_IN;
            rout_en = 1'b1;
         end
         S_T4: begin
            strb     = P_ZLO_IN | P_ZHI_IN;
            op_sel   = opc;
            rout_en  = is_bin || is_wide || is_un;
            rout_idx = is_un ? rb : rc;
         end
         S_T5: begin
            if (is_wide) begin
               strb = P_ZLO_OUT | P_LO_IN;
            end else begin
               strb   = P_ZLO_OUT;
               rin_en = is_bin || is_un;
            end
         end
         S_T6:   strb     = P_ZHI_OUT | P_HI_IN;
         S_ILL:  ill_out  = 1'b1;
         S_HALT: halt_out = 1'b1;
         default: ;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_sel
         assign rin_vec[gi]  = rin_en  && (rin_idx  == 4'(gi));
         assign rout_vec[gi] = rout_en && (rout_idx == 4'(gi));
      end
   endgenerate

   assign {bus.pc_out, bus.pc_increment, bus.mar_in, bus.pc_in, bus.read, bus.mdr_in,
           bus.mdr_out, bus.ir_in, bus.y_in, bus.zlow_in, bus.zhigh_in, bus.zlow_out,
           bus.zhigh_out, bus.lo_in, bus.hi_in} = strb;
   assign bus.rin     = rin_vec;
   assign bus.rout    = rout_vec;
   assign bus.op_code = OPW'(op_sel);
   assign bus.illegal = ill_out;
   assign bus.halted  = halt_out;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Table-driven, scoreboard-checked bench for alu_instr_sequencer (either build of SINGLE_STEP_EN).
module tb_alu_instr_sequencer;

   localparam logic [14:0] PC_OUT  = 15'h4000;
   localparam logic [14:0] PC_INC  = 15'h2000;
   localparam logic [14:0] MAR_IN  = 15'h1000;
   localparam logic [14:0] PC_IN   = 15'h0800;
   localparam logic [14:0] READ    = 15'h0400;
   localparam logic [14:0] MDR_IN  = 15'h0200;
   localparam logic [14:0] MDR_OUT = 15'h0100;
   localparam logic [14:0] IR_IN   = 15'h0080;
   localparam logic [14:0] Y_IN    = 15'h0040;
   localparam logic [14:0] ZLO_IN  = 15'h0020;
   localparam logic [14:0] ZHI_IN  = 15'h0010;
   localparam logic [14:0] ZLO_OUT = 15'h0008;
   localparam logic [14:0] ZHI_OUT = 15'h0004;
   localparam logic [14:0] LO_IN   = 15'h0002;
   localparam logic [14:0] HI_IN   = 15'h0001;
   localparam logic [14:0] ST0 = PC_OUT | PC_INC | MAR_IN | ZLO_IN | ZHI_IN;
   localparam logic [14:0] ST1 = ZLO_OUT | PC_IN | READ | MDR_IN;
   localparam logic [14:0] ST2 = MDR_OUT | IR_IN;

   localparam logic [31:0] I_SHR  = 32'h4A2B8000; // Ra=4 Rb=5 Rc=7
   localparam logic [31:0] I_ADD  = 32'h18788000; // Ra=0 Rb=15 Rc=1
   localparam logic [31:0] I_MUL  = 32'h78B00000; // Rb=6 Rc=0
   localparam logic [31:0] I_NOT  = 32'h91180000; // Ra=2 Rb=3
   localparam logic [31:0] I_ILL  = 32'hF8000000;
   localparam logic [31:0] I_HALT = 32'hD8000000;

   typedef struct {
      logic        clr;
      logic        run;
      logic [31:0] ir;
      logic [14:0] strb;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  op;
      logic        ill;
      logic        halt;
   } vec_t;

   logic clk = 1'b0;
   logic clr;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   alu_instr_sequencer_if #(.NREGS(16), .OPW(5)) bus ();

   alu_instr_sequencer #(.NREGS(16), .OPW(5)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   logic [14:0] act_strb;
   assign act_strb = {bus.pc_out, bus.pc_increment, bus.mar_in, bus.pc_in, bus.read,
                      bus.mdr_in, bus.mdr_out, bus.ir_in, bus.y_in, bus.zlow_in,
                      bus.zhigh_in, bus.zlow_out, bus.zhigh_out, bus.lo_in, bus.hi_in};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic c, input logic r, input logic [31:0] i, input logic [14:0] s,
                      input logic [15:0] ri, input logic [15:0] ro, input logic [4:0] o,
                      input logic il, input logic h);
      vec_t v;
      v.clr = c; v.run = r; v.ir = i; v.strb = s; v.rin = ri; v.rout = ro;
      v.op = o; v.ill = il; v.halt = h;
      vecs.push_back(v);
   endtask

   task automatic pulse_step();
      @(negedge clk);
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
   endtask

   initial begin
      vec_t e;
      int   lat;

      // Each record: inputs for this cycle and the outputs expected in the present state.
      add(1, 0, 32'h0, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);           // IDLE under clr
      add(0, 0, 32'h0, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);           // IDLE, run low holds
      add(0, 1, I_SHR, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);           // IDLE -> T0
      add(0, 1, I_SHR, ST0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_SHR, ST1, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_SHR, ST2, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_SHR, Y_IN, 16'h0, 16'h0020, 5'd0, 0, 0);
      add(0, 1, I_SHR, ZLO_IN | ZHI_IN, 16'h0, 16'h0080, 5'b01001, 0, 0);
      add(0, 1, I_SHR, ZLO_OUT, 16'h0010, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ADD, ST0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ADD, ST1, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ADD, ST2, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ADD, Y_IN, 16'h0, 16'h8000, 5'd0, 0, 0);
      add(0, 1, I_ADD, ZLO_IN | ZHI_IN, 16'h0, 16'h0002, 5'b00011, 0, 0);
      add(0, 1, I_ADD, ZLO_OUT, 16'h0001, 16'h0, 5'd0, 0, 0);
      // run dropped mid-instruction must not abort the MUL
      add(0, 1, I_MUL, ST0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 0, I_MUL, ST1, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 0, I_MUL, ST2, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 0, I_MUL, Y_IN, 16'h0, 16'h0040, 5'd0, 0, 0);
      add(0, 0, I_MUL, ZLO_IN | ZHI_IN, 16'h0, 16'h0001, 5'b01111, 0, 0);
      add(0, 0, I_MUL, ZLO_OUT | LO_IN, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_MUL, ZHI_OUT | HI_IN, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_NOT, ST0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_NOT, ST1, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_NOT, ST2, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_NOT, ZLO_IN | ZHI_IN, 16'h0, 16'h0008, 5'b10010, 0, 0);
      add(0, 0, I_NOT, ZLO_OUT, 16'h0004, 16'h0, 5'd0, 0, 0);
      add(0, 0, I_NOT, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ILL, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ILL, ST0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ILL, ST1, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ILL, ST2, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_ILL, 15'h0, 16'h0, 16'h0, 5'd0, 1, 0);
      add(0, 1, I_HALT, ST0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_HALT, ST1, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_HALT, ST2, 16'h0, 16'h0, 5'd0, 0, 0);
      for (int k = 0; k < 20; k++) add(0, 1, I_HALT, 15'h0, 16'h0, 16'h0, 5'd0, 0, 1);
      add(1, 1, I_HALT, 15'h0, 16'h0, 16'h0, 5'd0, 0, 1);
      add(0, 0, I_HALT, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);
      // clr during T4 aborts the instruction
      add(0, 1, I_SHR, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_SHR, ST0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_SHR, ST1, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_SHR, ST2, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 1, I_SHR, Y_IN, 16'h0, 16'h0020, 5'd0, 0, 0);
      add(1, 1, I_SHR, ZLO_IN | ZHI_IN, 16'h0, 16'h0080, 5'b01001, 0, 0);
      add(0, 0, I_SHR, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);
      add(0, 0, I_SHR, 15'h0, 16'h0, 16'h0, 5'd0, 0, 0);

      clr      = 1'b1;
      bus.run  = 1'b0;
      bus.step = 1'b0;
      bus.ir   = 32'h0;
      @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         clr     = vecs[i].clr;
         bus.run = vecs[i].run;
         bus.ir  = vecs[i].ir;
`ifdef SINGLE_STEP_EN
         bus.step = 1'b1;
`endif
         sb.push_back(vecs[i]);
         #1;
         e = sb.pop_front();
         $display("vec %0d: strb=%h rin=%h rout=%h op=%b ill=%b halt=%b",
                  i, act_strb, bus.rin, bus.rout, bus.op_code, bus.illegal, bus.halted);
         chk($sformatf("strobes[%0d]", i), 32'(act_strb), 32'(e.strb));
         chk($sformatf("rin[%0d]", i), 32'(bus.rin), 32'(e.rin));
         chk($sformatf("rout[%0d]", i), 32'(bus.rout), 32'(e.rout));
         chk($sformatf("op_code[%0d]", i), 32'(bus.op_code), 32'(e.op));
         chk($sformatf("illegal[%0d]", i), 32'(bus.illegal), 32'(e.ill));
         chk($sformatf("halted[%0d]", i), 32'(bus.halted), 32'(e.halt));
`ifdef SINGLE_STEP_EN
         @(negedge clk);
         bus.step = 1'b0;
`endif
      end

`ifdef SINGLE_STEP_EN
      // Park in T3 with step low: nothing may move until the next pulse.
      @(negedge clk);
      clr = 1'b1; bus.run = 1'b1; bus.ir = I_SHR;
      @(negedge clk);
      clr = 1'b0;
      for (int k = 0; k < 4; k++) pulse_step();
      for (int k = 0; k < 10; k++) begin
         #1;
         $display("hold %0d: strb=%h rout=%h", k, act_strb, bus.rout);
         chk($sformatf("hold_strb[%0d]", k), 32'(act_strb), 32'(Y_IN));
         chk($sformatf("hold_rout[%0d]", k), 32'(bus.rout), 32'h0020);
         @(negedge clk);
      end
      pulse_step();
      #1;
      $display("step to T4: op=%b rout=%h", bus.op_code, bus.rout);
      chk("step_op_code", 32'(bus.op_code), 32'b01001);
      chk("step_rout", 32'(bus.rout), 32'h0080);
`else
      // Latency: MUL from T0 to the hi_in cycle, NOT from T0 to its rin cycle.
      @(negedge clk);
      clr = 1'b1; bus.run = 1'b0; bus.ir = I_MUL;
      @(negedge clk);
      clr = 1'b0; bus.run = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         #1;
         if (bus.hi_in) lat = k;
      end
      $display("MUL latency: %0d cycles", lat);
      chk("mul_latency", 32'(lat), 32'd7);

      @(negedge clk);
      clr = 1'b1; bus.run = 1'b0; bus.ir = I_NOT;
      @(negedge clk);
      clr = 1'b0; bus.run = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         #1;
         if (bus.rin != 16'h0) lat = k;
      end
      $display("NOT latency: %0d cycles", lat);
      chk("not_latency", 32'(lat), 32'd5);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
